// File: rtl/pmem_burst_adaptor_pkg.sv
// Shared types and geometry for the L2-to-memory burst adaptor.
package pmem_burst_types;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned BEAT_W   = 64;
  localparam int unsigned BEATS    = LINE_W / BEAT_W;
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pmem_burst_adaptor.sv
// Splits 256-bit L2 line transfers into 4x64-bit memory bursts and reassembles reads.
// Optional perf counters: define PMEM_BURST_ADAPTOR_PERF_EN.
module pmem_burst_adaptor
  import pmem_burst_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  output logic                resp_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [BEAT_W-1:0]   burst_o,
`ifdef PMEM_BURST_ADAPTOR_PERF_EN
  output logic [31:0]         read_lines_o,
  output logic [31:0]         write_lines_o,
  output logic [31:0]         stall_cycles_o,
`endif
  input  logic [BEAT_W-1:0]   burst_i,
  input  logic                resp_i
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_beat;
  logic [31:0]         r_addr;
  logic [LINE_W-1:0]   r_wline;
  logic [LINE_W-1:0]   r_line;
  logic [7:0]          w_lsb;

  assign w_lsb = {r_beat, 6'd0};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (write_i)     w_next = WRITE;
        else if (read_i) w_next = READ;
      end
      READ, WRITE: begin
        if (resp_i && (r_beat == 2'd3)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // beat is a 2-bit counter, so the 3->0 wrap coincides with the exit to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (write_i) begin
            r_wline <= line_i;
            r_addr  <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            r_beat  <= '0;
          end else if (read_i) begin
            r_addr  <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            r_beat  <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            r_line[w_lsb +: BEAT_W] <= burst_i;
            r_beat                  <= r_beat + 2'd1;
          end
        end
        WRITE: begin
          if (resp_i) r_beat <= r_beat + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign read_o    = (r_state == READ);
  assign write_o   = (r_state == WRITE);
  assign resp_o    = (r_state == DONE);
  assign address_o = r_addr;
  assign line_o    = r_line;
  assign burst_o   = (r_state == WRITE) ? r_wline[w_lsb +: BEAT_W] : '0;

`ifdef PMEM_BURST_ADAPTOR_PERF_EN
  logic [31:0] r_rd_lines;
  logic [31:0] r_wr_lines;
  logic [31:0] r_stalls;
  logic        w_done_entry;

  assign w_done_entry = (w_next == DONE) && (r_state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_lines <= '0;
      r_wr_lines <= '0;
      r_stalls   <= '0;
    end else begin
      if (w_done_entry && (r_state == READ))  r_rd_lines <= r_rd_lines + 32'd1;
      if (w_done_entry && (r_state == WRITE)) r_wr_lines <= r_wr_lines + 32'd1;
      if (((r_state == READ) || (r_state == WRITE)) && !resp_i)
        r_stalls <= r_stalls + 32'd1;
    end
  end

  assign read_lines_o   = r_rd_lines;
  assign write_lines_o  = r_wr_lines;
  assign stall_cycles_o = r_stalls;
`endif

endmodule

// File: doc/pmem_burst_adaptor.md
# pmem_burst_adaptor

Converts whole-line (256-bit) read and write requests from the L2 cache controller into 4-beat, 64-bit bursts on the physical memory port, and reassembles read bursts into a full line. It sits directly downstream of the L2 controller, between its pmem_* signals and main memory. It makes exactly one memory transaction per L2 request and returns a single-cycle response when the whole line has moved.

## Interface
Parameters (fixed, from package):
- LINE_W, 256, line width in bits
- BEAT_W, 64, memory beat width in bits
- BEATS, 4, beats per line (LINE_W/BEAT_W)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- address_i  in  32  line address from L2
- read_i  in  1  line read request, held until resp_o
- write_i  in  1  line write request, held until resp_o
- line_i  in  256  write data, sampled on acceptance
- line_o  out  256  assembled read line
- resp_o  out  1  one-cycle completion pulse to L2
- address_o  out  32  burst address to memory, low 5 bits zero
- read_o  out  1  burst read request to memory
- write_o  out  1  burst write request to memory
- burst_o  out  64  write beat to memory
- burst_i  in  64  read beat from memory
- resp_i  in  1  memory beat-transfer strobe

## Operation
- States: IDLE, READ, WRITE, DONE. Beat counter beat[1:0].
- IDLE: if write_i, latch line_i and {address_i[31:5],5'b0}, clear beat, go to WRITE. Else if read_i, latch the address, clear beat, go to READ. If both are high, write wins.
- READ: read_o=1. On each cycle with resp_i=1, store burst_i into line_o bits [64*beat+63:64*beat] and increment beat. When resp_i arrives with beat==3, go to DONE.
- WRITE: write_o=1; burst_o = latched line bits [64*beat+63:64*beat]. On each resp_i, increment beat. When resp_i arrives with beat==3, go to DONE.
- DONE: resp_o=1 for exactly one cycle, then go to IDLE.
- line_o stays stable from DONE until the first beat of the next read overwrites it. Writes never alter line_o.
- beat wraps 3->0 only at the state exit. Cycles with resp_i=0 are stalls: no state or beat change.
- If read_i or write_i drops mid-burst, it is ignored; the burst completes. resp_i in IDLE or DONE is ignored.
- address_i and line_i changes after acceptance have no effect.

## Timing
- Reset values: read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0, state=IDLE, beat=0.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- A request seen high at edge N puts read_o/write_o high from cycle N+1.
- With 4 consecutive resp_i cycles, resp_o rises one cycle after the 4th beat. Minimum latency from request to resp_o is 6 cycles.
- A request still high in the cycle after DONE (IDLE) is accepted as a new transaction. This supports WRITE_BACK followed by ALLOCATE.
- rst mid-burst: state returns to IDLE and all outputs clear on the next edge. The partial line is discarded.

## Configuration
- PMEM_BURST_ADAPTOR_PERF_EN defined adds these ports:
  - read_lines_o out 32: count of completed read lines.
  - write_lines_o out 32: count of completed write lines.
  - stall_cycles_o out 32: count of READ/WRITE cycles with resp_i=0.
  - All three counters increment at DONE entry (the stall counter per stall cycle), wrap modulo 2^32, and clear on rst.
- Macro undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Package pmem_burst_types: the state enum (IDLE, READ, WRITE, DONE) and the constants LINE_W, BEAT_W, BEATS, OFFSET_W=5.
- Single module; no sub-module. The beat counter and datapath are inline.

## Test plan
- Read, no stalls: read_i=1, address_i=0x0000_1234. Then address_o=0x0000_1220 and read_o=1. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 produce line_o={44..,33..,22..,11..} and a single resp_o pulse at cycle 6.
- Write with stalls: line_i=0xAAAA..._DDDD (beats A,B,C,D), resp_i pattern 1,0,1,0,0,1,1. Then burst_o walks through beats 0..3 in order, stall_cycles_o=3, and resp_o is one cycle.
- Write-back then allocate: write_i for 4 beats, then read_i held high through the cycle after DONE. Then the second transaction starts with no extra idle cycle and line_o is updated only by the read.
- Simultaneous read_i=write_i=1: only write_o asserts, and read_o stays 0 throughout.
- rst asserted after beat 2 of a read: next cycle read_o=0, resp_o=0, line_o=0. A fresh read then completes normally.
- Request dropped mid-burst: read_i falls after beat 1. Then read_o stays high until beat 4 and resp_o still pulses once.
